// File: rtl/mc_control_unit.sv
// ============================================================================
//  Module   : mc_control_unit
//  Brief    : Multicycle MIPS control unit. A Moore FSM that steps each
//             instruction through fetch, decode, execute, memory and
//             write-back, and drives every datapath select and enable.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_control_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUCtrl,
   output logic [1:0] PCSource,
   output logic       ExtCtrl,
   output logic       Halted,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_IF   = 4'd0,
      S_ID   = 4'd1,
      S_MADR = 4'd2,
      S_MRD  = 4'd3,
      S_MWB  = 4'd4,
      S_MWR  = 4'd5,
      S_REX  = 4'd6,
      S_RWB  = 4'd7,
      S_BR   = 4'd8,
      S_JMP  = 4'd9,
      S_IEX  = 4'd10,
      S_IWB  = 4'd11,
      S_HALT = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t state_q;
   state_t state_d;

   // Raw (pre-reset-gating) versions of the enables that reset must mask.
   logic pc_write_raw;
   logic mem_read_raw;
   logic mem_write_raw;
   logic ir_write_raw;
   logic reg_write_raw;

   // State register; reset always lands in fetch.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IF;
      else     state_q <= state_d;
   end

   // Next-state logic and Moore outputs (plus the listed opcode/funct/zero terms).
   always_comb begin
      state_d       = S_IF;
      pc_write_raw  = 1'b0;
      mem_read_raw  = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      IorD          = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUCtrl       = 3'b000;
      PCSource      = 2'b00;
      Halted        = 1'b0;
      case (state_q)
         S_IF: begin
            state_d      = S_ID;
            mem_read_raw = 1'b1;
            ir_write_raw = 1'b1;
            pc_write_raw = 1'b1;
            ALUSrcB      = 2'b01;
            ALUCtrl      = ALU_ADD;
         end
         S_ID: begin
            // Branch target is precomputed into ALUOut here.
            ALUSrcB = 2'b11;
            ALUCtrl = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW:                      state_d = S_MADR;
               OP_RTYPE:                          state_d = S_REX;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEX;
               OP_BEQ, OP_BNE:                    state_d = S_BR;
               OP_J:                              state_d = S_JMP;
               OP_HALT:                           state_d = S_HALT;
               default:                           state_d = S_IF;
            endcase
         end
         S_MADR: begin
            state_d = (opcode == OP_SW) ? S_MWR : S_MRD;
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUCtrl = ALU_ADD;
         end
         S_MRD: begin
            state_d      = S_MWB;
            mem_read_raw = 1'b1;
            IorD         = 1'b1;
         end
         S_MWB: begin
            reg_write_raw = 1'b1;
            MemtoReg      = 1'b1;
         end
         S_MWR: begin
            mem_write_raw = 1'b1;
            IorD          = 1'b1;
         end
         S_REX: begin
            state_d = S_RWB;
            ALUSrcA = 1'b1;
            case (funct)
               6'b100010: ALUCtrl = ALU_SUB;
               6'b100100: ALUCtrl = ALU_AND;
               6'b100101: ALUCtrl = ALU_OR;
               6'b101010: ALUCtrl = ALU_SLT;
               default:   ALUCtrl = ALU_ADD;
            endcase
         end
         S_RWB: begin
            reg_write_raw = 1'b1;
            RegDst        = 1'b1;
         end
         S_BR: begin
            ALUSrcA      = 1'b1;
            ALUCtrl      = ALU_SUB;
            PCSource     = 2'b01;
            pc_write_raw = (opcode == OP_BNE) ? ~zero : zero;
         end
         S_JMP: begin
            pc_write_raw = 1'b1;
            PCSource     = 2'b10;
         end
         S_IEX: begin
            state_d = S_IWB;
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (opcode)
               OP_SLTI: ALUCtrl = ALU_SLT;
               OP_ANDI: ALUCtrl = ALU_AND;
               OP_ORI:  ALUCtrl = ALU_OR;
               default: ALUCtrl = ALU_ADD;
            endcase
         end
         S_IWB: begin
            reg_write_raw = 1'b1;
         end
         S_HALT: begin
            state_d = S_HALT;
            Halted  = 1'b1;
         end
         default: state_d = S_IF;
      endcase
   end

   // Reset masks every enable combinationally so nothing fires during reset.
   always_comb begin
      PCWrite  = pc_write_raw  & ~rst;
      MemRead  = mem_read_raw  & ~rst;
      MemWrite = mem_write_raw & ~rst;
      IRWrite  = ir_write_raw  & ~rst;
      RegWrite = reg_write_raw & ~rst;
   end

   // Extender mode: zero-extend only for the logical immediates.
   always_comb begin
      ExtCtrl = ~((opcode == OP_ANDI) || (opcode == OP_ORI));
   end

   assign State = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// ============================================================================
//  Module   : tb_mc_control_unit
//  Brief    : Directed self-checking bench for mc_control_unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_control_unit;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
   logic       RegWrite, ALUSrcA, ExtCtrl, Halted;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUCtrl;
   logic [3:0] State;

   int checks = 0;
   int errors = 0;

   mc_control_unit dut (
      .clk      (clk),
      .rst      (rst),
      .opcode   (opcode),
      .funct    (funct),
      .zero     (zero),
      .PCWrite  (PCWrite),
      .IorD     (IorD),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .IRWrite  (IRWrite),
      .RegDst   (RegDst),
      .MemtoReg (MemtoReg),
      .RegWrite (RegWrite),
      .ALUSrcA  (ALUSrcA),
      .ALUSrcB  (ALUSrcB),
      .ALUCtrl  (ALUCtrl),
      .PCSource (PCSource),
      .ExtCtrl  (ExtCtrl),
      .Halted   (Halted),
      .State    (State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle away from the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      opcode = 6'b000000;
      funct  = 6'b000000;
      zero   = 1'b0;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_state",    State,   0);
         chk("rst_pcwrite",  PCWrite, 0);
         chk("rst_irwrite",  IRWrite, 0);
         chk("rst_memread",  MemRead, 0);
      end
      rst    = 1'b0;
      opcode = 6'b100011;   // lw
      #1;
      chk("if_state",   State,   0);
      chk("if_pcwrite", PCWrite, 1);
      chk("if_irwrite", IRWrite, 1);
      chk("if_memread", MemRead, 1);
      chk("if_alusrcb", ALUSrcB, 2'b01);
      chk("lw_ext_if",  ExtCtrl, 1);

      // lw: 0,1,2,3,4,0
      tick(); chk("lw_s1", State, 1); chk("lw_ext_id", ExtCtrl, 1);
      chk("id_alusrcb", ALUSrcB, 2'b11); chk("id_aluctrl", ALUCtrl, 3'b010);
      tick(); chk("lw_s2", State, 2); chk("madr_srca", ALUSrcA, 1); chk("madr_srcb", ALUSrcB, 2'b10);
      tick(); chk("lw_s3", State, 3); chk("mrd_memread", MemRead, 1); chk("mrd_iord", IorD, 1);
      chk("mrd_regwrite", RegWrite, 0);
      tick(); chk("lw_s4", State, 4); chk("mwb_regwrite", RegWrite, 1); chk("mwb_memtoreg", MemtoReg, 1);
      chk("mwb_regdst", RegDst, 0); chk("lw_ext_wb", ExtCtrl, 1);
      tick(); chk("lw_s0", State, 0);

      // ori
      opcode = 6'b001101;
      tick(); chk("ori_s1", State, 1); chk("ori_ext", ExtCtrl, 0);
      tick(); chk("ori_s10", State, 10); chk("ori_aluctrl", ALUCtrl, 3'b001); chk("ori_iex_rw", RegWrite, 0);
      tick(); chk("ori_s11", State, 11); chk("ori_iwb_rw", RegWrite, 1); chk("ori_iwb_m2r", MemtoReg, 0);
      tick(); chk("ori_s0", State, 0); chk("ori_if_rw", RegWrite, 0);

      // addi
      opcode = 6'b001000;
      tick(); chk("addi_s1", State, 1); chk("addi_ext", ExtCtrl, 1);
      tick(); chk("addi_s10", State, 10); chk("addi_aluctrl", ALUCtrl, 3'b010);
      tick(); chk("addi_s11", State, 11); chk("addi_iwb_rw", RegWrite, 1);
      tick(); chk("addi_s0", State, 0);

      // beq taken
      opcode = 6'b000100;
      tick(); chk("beq1_s1", State, 1);
      tick(); zero = 1'b1; #1;
      chk("beq1_s8", State, 8); chk("beq1_pcwrite", PCWrite, 1);
      chk("br_pcsource", PCSource, 2'b01); chk("br_aluctrl", ALUCtrl, 3'b110);
      tick(); chk("beq1_s0", State, 0);

      // beq not taken
      tick(); chk("beq0_s1", State, 1);
      tick(); zero = 1'b0; #1;
      chk("beq0_s8", State, 8); chk("beq0_pcwrite", PCWrite, 0);
      tick(); chk("beq0_s0", State, 0);

      // bne with zero=0 -> taken
      opcode = 6'b000101;
      tick(); chk("bne_s1", State, 1);
      tick(); chk("bne_s8", State, 8); chk("bne_pcwrite", PCWrite, 1); chk("bne_pcsource", PCSource, 2'b01);
      tick(); chk("bne_s0", State, 0);

      // j
      opcode = 6'b000010;
      tick(); chk("j_s1", State, 1);
      tick(); chk("j_s9", State, 9); chk("j_pcwrite", PCWrite, 1); chk("j_pcsource", PCSource, 2'b10);
      tick(); chk("j_s0", State, 0);

      // unknown opcode acts as a NOP (2 cycles)
      opcode = 6'b010101;
      tick(); chk("nop_s1", State, 1);
      tick(); chk("nop_s0", State, 0);

      // R-type slt
      opcode = 6'b000000;
      funct  = 6'b101010;
      tick(); chk("slt_s1", State, 1);
      tick(); chk("slt_s6", State, 6); chk("slt_aluctrl", ALUCtrl, 3'b111); chk("rex_srcb", ALUSrcB, 2'b00);
      tick(); chk("slt_s7", State, 7); chk("rwb_regdst", RegDst, 1); chk("rwb_regwrite", RegWrite, 1);
      tick(); chk("slt_s0", State, 0);

      // R-type with unknown funct defaults to ADD
      funct = 6'b000111;
      tick(); tick(); chk("rbad_s6", State, 6); chk("rbad_aluctrl", ALUCtrl, 3'b010);
      tick(); tick(); chk("rbad_s0", State, 0);

      // halt
      opcode = 6'b111111;
      tick(); chk("halt_s1", State, 1);
      for (int i = 0; i < 11; i++) begin
         tick();
         chk("halt_state",  State,  12);
         chk("halt_flag",   Halted, 1);
         chk("halt_pcw",    PCWrite, 0);
         chk("halt_memrd",  MemRead, 0);
      end
      rst = 1'b1;
      tick(); chk("halt_rst_state", State, 0); chk("halt_rst_flag", Halted, 0);
      rst = 1'b0;

      // sw interrupted by reset during MWR
      opcode = 6'b101011;
      tick(); chk("sw_s1", State, 1);
      tick(); chk("sw_s2", State, 2);
      tick(); chk("sw_s5", State, 5); chk("sw_memwrite", MemWrite, 1); chk("sw_iord", IorD, 1);
      rst = 1'b1; #1;
      chk("sw_rst_memwrite", MemWrite, 0);
      chk("sw_rst_state_hold", State, 5);
      tick(); chk("sw_rst_state", State, 0); chk("sw_rst_mw2", MemWrite, 0);
      chk("sw_rst_rw", RegWrite, 0); chk("sw_rst_pcw", PCWrite, 0);
      rst = 1'b0; #1;
      chk("sw_post_pcw", PCWrite, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle MIPS control unit: a Moore finite-state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives every datapath select and write enable. It sits directly upstream of the immediate extender and produces that extender's `ExtCtrl` sign/zero select from the instruction opcode. The opcode and funct inputs come from the instruction register, which is stable from the cycle after fetch.

## Interface
- No parameters. Encodings are fixed as listed below.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, valid during the branch state.
- `PCWrite` out 1: PC load enable, with the branch condition already resolved.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 1: write-register select; 0 = rt, 1 = rd.
- `MemtoReg` out 1: write-back data select; 0 = ALUOut, 1 = MDR.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A input; 0 = PC, 1 = register A.
- `ALUSrcB` out 2: ALU B input; 00 = register B, 01 = constant 4, 10 = ext(imm), 11 = ext(imm)<<2.
- `ALUCtrl` out 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `PCSource` out 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}.
- `ExtCtrl` out 1: extender mode; 1 = sign-extend, 0 = zero-extend.
- `Halted` out 1: high while the FSM is in the HALT state.
- `State` out 4: current state code, for debug.

## Operation
Supported opcodes:
- R-type 000000, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
- addi 001000, slti 001010, andi 001100, ori 001101.
- lw 100011, sw 101011.
- beq 000100, bne 000101.
- j 000010.
- halt 111111.

State encoding: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, REX=6, RWB=7, BR=8, JMP=9, IEX=10, IWB=11, HALT=12.

Transitions:
- IF → ID.
- ID → MADR for lw/sw; REX for R-type; IEX for immediates; BR for beq/bne; JMP for j; HALT for halt; IF for any other opcode (executes as a NOP).
- MADR → MRD for lw, MWR for sw. MRD → MWB. MWB, MWR, RWB, IWB, BR, JMP → IF.
- REX → RWB. IEX → IWB.
- HALT → HALT; only `rst` leaves it.
- Codes 13–15 → IF.

Outputs by state (every output not listed is 0):
- IF: MemRead, IRWrite, PCWrite; ALUSrcA=0, ALUSrcB=01, ALUCtrl=ADD, PCSource=00.
- ID: ALUSrcA=0, ALUSrcB=11, ALUCtrl=ADD. This precomputes the branch target into ALUOut.
- MADR: ALUSrcA=1, ALUSrcB=10, ALUCtrl=ADD.
- MRD: MemRead, IorD=1.
- MWR: MemWrite, IorD=1.
- MWB: RegWrite, RegDst=0, MemtoReg=1.
- REX: ALUSrcA=1, ALUSrcB=00, ALUCtrl decoded from funct. An unknown funct gives ADD.
- RWB: RegWrite, RegDst=1, MemtoReg=0.
- IEX: ALUSrcA=1, ALUSrcB=10. ALUCtrl is ADD for addi, SLT for slti, AND for andi, OR for ori.
- IWB: RegWrite, RegDst=0, MemtoReg=0.
- BR: ALUSrcA=1, ALUSrcB=00, ALUCtrl=SUB, PCSource=01. PCWrite = zero for beq, ~zero for bne.
- JMP: PCWrite, PCSource=10.
- HALT: Halted=1, all enables 0.

ExtCtrl is decoded combinationally from opcode in every state:
- 0 for andi and ori.
- 1 for all other opcodes. This includes ID, so the branch offset is sign-extended.

Reset:
- While `rst`=1, PCWrite, MemRead, MemWrite, IRWrite and RegWrite are forced to 0 combinationally. No spurious fetch or write occurs during reset.
- On the first rising edge with `rst`=1, State becomes IF.
- If `rst` is asserted mid-instruction, that instruction is abandoned. No write enables assert after the reset edge.

## Timing
- Outputs are Moore and combinational from the state register; opcode, funct and zero add combinational terms where listed above.
- One state per clock; no stalls.
- Cycle counts per instruction: lw 5; sw, R-type and immediates 4; beq, bne and j 3; unknown opcode 2.
- The first fetch occurs in the first cycle after `rst` deasserts.
- `zero` is sampled only in BR. Changes on opcode or funct outside ID, REX, IEX, BR and MADR have no effect on the state sequence.

## Test plan
- Hold reset 3 cycles, then release. Required: State=0 throughout; PCWrite, IRWrite and MemRead are 0 during reset and 1 in the first cycle after release.
- lw (opcode 100011): State sequence 0,1,2,3,4,0. MemRead=1 with IorD=1 in state 3. RegWrite=1 with MemtoReg=1 in state 4. ExtCtrl=1 throughout.
- ori (001101), then addi (001000): ExtCtrl=0 for ori and 1 for addi. IEX gives ALUCtrl 001 for ori and 010 for addi. RegWrite is asserted in IWB only.
- beq with zero=1, then zero=0; bne with zero=0: PCWrite in BR is 1, 0 and 1 respectively. PCSource=01 in BR. Each instruction takes 3 cycles.
- R-type slt (funct 101010): REX gives ALUCtrl=111. RWB gives RegDst=1 and RegWrite=1. Then the halt opcode: State stays 12 and Halted=1 for 10 or more cycles, until `rst`.
- Assert rst during MWR of sw: MemWrite drops to 0 in the same cycle, and State=0 on the next edge.
